// File: rtl/gpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared encodings for the core scheduler state and the
//                instruction fetcher state.
//  Revision    : 1.0  initial release
// ============================================================================
package gpu_pkg;

    // Core scheduler states the fetcher reacts to
    typedef logic [2:0] core_state_t;
    localparam core_state_t c_core_fetch  = 3'b001;
    localparam core_state_t c_core_decode = 3'b010;

    // Fetcher state, as seen by the core on fetcher_state
    typedef logic [2:0] fetcher_state_t;
    localparam fetcher_state_t c_fs_idle     = 3'b000;
    localparam fetcher_state_t c_fs_fetching = 3'b001;
    localparam fetcher_state_t c_fs_fetched  = 3'b010;

endpackage : gpu_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Circular {addr, data} FIFO holding prefetched instructions.
//                Flush wins over push and pop; DEPTH need not be a power
//                of two, so pointers wrap explicitly.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int A     = 8,
    parameter int D     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [A-1:0]                 push_addr,
    input  logic [D-1:0]                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         head_valid,
    output logic [A-1:0]                 head_addr,
    output logic [D-1:0]                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [A-1:0]       r_addr_mem [DEPTH];
    logic [D-1:0]       r_data_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_push  = push && (r_count != c_cnt_w'(DEPTH));
    assign w_do_pop   = pop && (r_count != '0);
    assign head_valid = (r_count != '0);
    assign head_addr  = r_addr_mem[r_rd_ptr];
    assign head_data  = r_data_mem[r_rd_ptr];
    assign count      = r_count;

    // Pointer and occupancy tracking; flush empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents beyond count are don't-care so no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !reset) begin
            r_addr_mem[r_wr_ptr] <= push_addr;
            r_data_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/prefetch_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : prefetch_fetcher
//  Description : Per-core instruction fetcher that streams sequential
//                instructions into a small queue while the core works, so a
//                FETCH at the queue head completes in one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module prefetch_fetcher
    import gpu_pkg::*;
#(
    parameter int PROG_MEM_ADDR_BITS = 8,
    parameter int PROG_MEM_DATA_BITS = 16,
    parameter int DEPTH              = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    core_state,
    input  logic [PROG_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                          prefetch_en,
    output logic                          mem_read_ask,
    output logic [PROG_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                          mem_read_get,
    input  logic [PROG_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                    fetcher_state,
    output logic [PROG_MEM_DATA_BITS-1:0] instr
);

    localparam int c_a     = PROG_MEM_ADDR_BITS;
    localparam int c_d     = PROG_MEM_DATA_BITS;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    fetcher_state_t     r_state;
    fetcher_state_t     w_state_next;
    logic               r_ask;
    logic [c_a-1:0]     r_addr;
    logic               r_stale;
    logic               r_demand;
    logic [c_a-1:0]     r_next_pf;
    logic [c_d-1:0]     r_instr;

    logic               w_head_valid;
    logic [c_a-1:0]     w_head_addr;
    logic [c_d-1:0]     w_head_data;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w:0]   w_occupancy;

    logic               w_is_fetch;
    logic               w_hit;
    logic               w_trail;
    logic               w_pop;
    logic               w_flush;
    logic               w_take;
    logic               w_get;
    logic               w_push;
    logic               w_can_issue;
    logic               w_issue_demand;
    logic               w_issue_pf;
    logic               w_issue;
    logic [c_a-1:0]     w_issue_addr;

    fetch_queue #(
        .DEPTH (DEPTH),
        .A     (c_a),
        .D     (c_d)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_addr  (r_addr),
        .push_data  (mem_read_data),
        .pop        (w_pop),
        .flush      (w_flush),
        .head_valid (w_head_valid),
        .head_addr  (w_head_addr),
        .head_data  (w_head_data),
        .count      (w_count)
    );

    assign w_is_fetch = (core_state == c_core_fetch);
    assign w_hit      = w_head_valid && (w_head_addr == current_pc);
    // Queue empty but the in-flight request is exactly the one wanted
    assign w_trail    = !w_head_valid && r_ask && (r_addr == current_pc);

    // A response only counts while a request is outstanding; one landing on
    // a flush cycle belongs to the abandoned stream and is dropped.
    assign w_get  = r_ask && mem_read_get;
    assign w_push = w_get && !r_stale && !w_flush;

    // Issue arbiter: demand refill beats prefetch, nothing issues on a flush
    assign w_occupancy    = {1'b0, w_count} + {{c_cnt_w{1'b0}}, r_ask};
    assign w_can_issue    = !r_ask && !w_flush;
    assign w_issue_demand = w_can_issue && r_demand;
    assign w_issue_pf     = w_can_issue && !r_demand && prefetch_en &&
                            (w_occupancy < (c_cnt_w + 1)'(DEPTH));
    assign w_issue        = w_issue_demand || w_issue_pf;
    assign w_issue_addr   = w_issue_demand ? current_pc : r_next_pf;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_fs_idle;
        else       r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_fs_idle:     if (w_is_fetch) w_state_next = w_hit ? c_fs_fetched : c_fs_fetching;
            c_fs_fetching: if (w_head_valid) w_state_next = c_fs_fetched;
            c_fs_fetched:  if (core_state == c_core_decode) w_state_next = c_fs_idle;
            default:       w_state_next = c_fs_idle;
        endcase
    end

    // FSM outputs: queue pop/flush and instruction capture
    always_comb begin
        w_pop   = 1'b0;
        w_flush = 1'b0;
        w_take  = 1'b0;
        case (r_state)
            c_fs_idle: begin
                if (w_is_fetch) begin
                    if (w_hit) begin
                        w_pop  = 1'b1;
                        w_take = 1'b1;
                    end else if (!w_trail) begin
                        w_flush = 1'b1;
                    end
                end
            end
            c_fs_fetching: begin
                w_pop  = w_head_valid;
                w_take = w_head_valid;
            end
            default: ;
        endcase
    end

    // Request handshake, prefetch pointer, demand-pending and stale tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ask     <= 1'b0;
            r_addr    <= '0;
            r_stale   <= 1'b0;
            r_demand  <= 1'b0;
            r_next_pf <= '0;
        end else begin
            if (w_get) begin
                r_ask <= 1'b0;
            end else if (w_issue) begin
                r_ask  <= 1'b1;
                r_addr <= w_issue_addr;
            end

            if (w_flush) begin
                r_next_pf <= current_pc;
                r_demand  <= 1'b1;
            end else if (w_issue) begin
                r_next_pf <= w_issue_addr + 1'b1;
                if (w_issue_demand) r_demand <= 1'b0;
            end

            if (w_get)                r_stale <= 1'b0;
            else if (w_flush && r_ask) r_stale <= 1'b1;
        end
    end

    // Instruction register, held stable while FETCHED
    always_ff @(posedge clk) begin
        if (reset)       r_instr <= '0;
        else if (w_take) r_instr <= w_head_data;
    end

    assign mem_read_ask     = r_ask;
    assign mem_read_address = r_addr;
    assign fetcher_state    = r_state;
    assign instr            = r_instr;

endmodule : prefetch_fetcher
`default_nettype wire

// File: tb/tb_prefetch_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_prefetch_fetcher
//  Description : Self-checking bench for prefetch_fetcher with a program
//                memory that answers each request three cycles after ask.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prefetch_fetcher;
    import gpu_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        prefetch_en;
    logic        mem_read_ask;
    logic [7:0]  mem_read_address;
    logic        mem_read_get;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instr;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_pc = 8'h00;
    logic [7:0]  ask_log [$];
    logic        log_prev = 1'b0;
    logic        prev_ask = 1'b0;
    logic [7:0]  prev_addr = 8'h00;

    localparam logic [2:0] c_core_exec = 3'b100;

    prefetch_fetcher #(
        .PROG_MEM_ADDR_BITS (8),
        .PROG_MEM_DATA_BITS (16),
        .DEPTH              (4)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .prefetch_en      (prefetch_en),
        .mem_read_ask     (mem_read_ask),
        .mem_read_address (mem_read_address),
        .mem_read_get     (mem_read_get),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instr            (instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory contents
    function automatic logic [15:0] mem_val(input logic [7:0] a);
        return {a ^ 8'hC3, ~a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory responder: sees ask, answers with a one-cycle get two cycles later
    initial begin : p_memory
        logic [7:0] a;
        mem_read_get  = 1'b0;
        mem_read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_read_ask) begin
                a = mem_read_address;
                @(posedge clk); #1;
                @(posedge clk); #1;
                mem_read_get  = 1'b1;
                mem_read_data = mem_val(a);
                @(posedge clk); #1;
                mem_read_get  = 1'b0;
                mem_read_data = '0;
            end
        end
    end

    // Request log: address of every new ask
    always @(negedge clk) begin
        if (mem_read_ask && !log_prev) ask_log.push_back(mem_read_address);
        log_prev <= mem_read_ask;
    end

    // Model compare: FETCHED must present mem[pc of the FETCH]; ask address stable
    always @(negedge clk) begin
        if (!reset && fetcher_state == c_fs_fetched)
            chk("instr_vs_model", {16'h0, instr}, {16'h0, mem_val(model_pc)});
        if (!reset && prev_ask && mem_read_ask)
            chk("addr_stable", {24'h0, mem_read_address}, {24'h0, prev_addr});
        prev_ask  <= mem_read_ask;
        prev_addr <= mem_read_address;
    end

    task automatic reset_dut();
        reset       = 1'b1;
        core_state  = c_core_exec;
        prefetch_en = 1'b0;
        current_pc  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_state", {29'h0, fetcher_state}, {29'h0, c_fs_idle});
        chk("rst_ask",   {31'h0, mem_read_ask}, 32'h0);
        chk("rst_addr",  {24'h0, mem_read_address}, 32'h0);
        chk("rst_instr", {16'h0, instr}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        ask_log.delete();
    endtask

    // Present FETCH; check latency (when exp_lat > 0) and instruction
    task automatic do_fetch(input logic [7:0] pc, input int exp_lat, input logic [15:0] exp_instr);
        int n;
        n          = 0;
        core_state = c_core_fetch;
        current_pc = pc;
        model_pc   = pc;
        do begin
            @(posedge clk); #1;
            n++;
        end while (fetcher_state != c_fs_fetched && n < 60);
        chk("fetched_reached", {29'h0, fetcher_state}, {29'h0, c_fs_fetched});
        if (exp_lat > 0) chk("fetch_latency", n, exp_lat);
        chk("fetch_instr", {16'h0, instr}, {16'h0, exp_instr});
        // PC changes while FETCHED must not disturb instr
        core_state = c_core_exec;
        current_pc = ~pc;
        @(posedge clk); #1;
        core_state = c_core_decode;
        @(posedge clk); #1;
        chk("idle_after_decode", {29'h0, fetcher_state}, {29'h0, c_fs_idle});
        core_state = c_core_exec;
    endtask

    task automatic chk_log(input string name, input int start, input logic [7:0] first, input int n);
        logic [7:0] e;
        e = first;
        for (int i = 0; i < n; i++) begin
            if (start + i < ask_log.size())
                chk(name, {24'h0, ask_log[start + i]}, {24'h0, e});
            e = e + 8'h01;
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : p_main
        int         n;
        logic [7:0] pc;
        reset         = 1'b1;
        core_state    = c_core_exec;
        current_pc    = 8'h00;
        prefetch_en   = 1'b0;

        // 1: demand-only fetch
        reset_dut();
        do_fetch(8'h10, 6, 16'hD3EF);
        gap(12);
        chk("t1_ask_count", ask_log.size(), 1);
        chk_log("t1_ask_addr", 0, 8'h10, 1);

        // 2: sequential stream with prefetch, queue capped at four entries
        reset_dut();
        prefetch_en = 1'b1;
        do_fetch(8'h10, 6, 16'hD3EF);
        gap(25);
        chk("t2_ask_count_full", ask_log.size(), 5);
        chk_log("t2_ask_seq", 0, 8'h10, 5);
        for (int i = 1; i <= 4; i++) begin
            pc = 8'h10 + 8'(i);
            do_fetch(pc, 1, mem_val(pc));
            gap(6);
        end

        // 3: branch while a prefetch is in flight
        reset_dut();
        prefetch_en = 1'b1;
        do_fetch(8'h10, 6, 16'hD3EF);
        n = 0;
        while (!(mem_read_ask && mem_read_address == 8'h13) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t3_pf13_seen", {24'h0, mem_read_address}, 32'h13);
        do_fetch(8'h40, 8, 16'h83BF);
        gap(10);
        chk_log("t3_ask_before", 0, 8'h10, 4);
        chk_log("t3_ask_after", 4, 8'h40, 2);

        // 4: prefetch across the address wrap
        reset_dut();
        prefetch_en = 1'b1;
        do_fetch(8'hFE, 6, mem_val(8'hFE));
        gap(25);
        chk("t4_ask_count", ask_log.size(), 5);
        chk_log("t4_ask_wrap", 0, 8'hFE, 5);
        do_fetch(8'hFF, 1, 16'h3C00);
        gap(6);
        do_fetch(8'h00, 1, 16'hC3FF);
        gap(6);

        // 5: reset while a request is outstanding; late get must be ignored
        reset_dut();
        core_state = c_core_fetch;
        current_pc = 8'h20;
        model_pc   = 8'h20;
        n = 0;
        while (!mem_read_ask && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_ask_seen", {31'h0, mem_read_ask}, 32'h1);
        reset      = 1'b1;
        core_state = c_core_exec;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5_ask_dropped", {31'h0, mem_read_ask}, 32'h0);
        chk("t5_state_idle", {29'h0, fetcher_state}, {29'h0, c_fs_idle});
        gap(6);
        chk("t5_ask_quiet", {31'h0, mem_read_ask}, 32'h0);
        do_fetch(8'h20, 6, 16'hE3DF);
        gap(4);

        // 6: mixed sequential runs and branches against the memory model
        pc = 8'h80;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) pc = 8'($urandom_range(0, 255));
            else                           pc = pc + 8'h01;
            prefetch_en = ($urandom_range(0, 4) != 0);
            do_fetch(pc, 0, mem_val(pc));
            gap($urandom_range(0, 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_prefetch_fetcher
`default_nettype wire
